// File: rtl/booth_pkg.sv
// Shared types and A-register command encodings for the Booth sequencer and its A-register stage.
package booth_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StEval,
        StShift,
        StDone
    } state_t;

    localparam logic [1:0] CTRL_LOAD  = 2'b00;
    localparam logic [1:0] CTRL_CLEAR = 2'b01;
    localparam logic [1:0] CTRL_SHR   = 2'b10;
    localparam logic [1:0] CTRL_HOLD  = 2'b11;

endpackage

// File: rtl/booth_qreg.sv
// Booth Q register with its q_m1 history bit; supports load, right shift and hold.
module booth_qreg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_val,
    input  logic             a_lsb,
    output logic [WIDTH-1:0] q,
    output logic             q_m1
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q    <= '0;
            q_m1 <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            q_m1 <= 1'b0;
        end else if (shift) begin
            // The A register's outgoing lsb becomes the new Q msb.
            q    <= {a_lsb, q[WIDTH-1:1]};
            q_m1 <= q[0];
        end
    end

endmodule

// File: rtl/booth_seq.sv
// Radix-2 Booth multiplier sequencer: FSM, iteration counter and Q register.
// Optional abort input is enabled by defining BOOTH_SEQ_ABORT_EN.
module booth_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
`ifdef BOOTH_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] multiplier,
    input  logic             a_lsb,
    output logic [1:0]       areg_ctrl,
    output logic             add_sub,
    output logic [WIDTH-1:0] q_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] q;
    logic            q_m1;
    logic            q_load, q_shift;

    booth_qreg #(
        .WIDTH(WIDTH)
    ) u_qreg (
        .clock    (clock),
        .resetn   (resetn),
        .load     (q_load),
        .shift    (q_shift),
        .load_val (multiplier),
        .a_lsb    (a_lsb),
        .q        (q),
        .q_m1     (q_m1)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        areg_ctrl = CTRL_HOLD;
        add_sub   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        q_load    = 1'b0;
        q_shift   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                areg_ctrl = CTRL_CLEAR;
                busy      = 1'b1;
                q_load    = 1'b1;
                count_d   = CW'(WIDTH);
                state_d   = StEval;
            end
            StEval: begin
                busy = 1'b1;
                case ({q[0], q_m1})
                    2'b01: begin
                        areg_ctrl = CTRL_LOAD;
                        add_sub   = 1'b0;
                    end
                    2'b10: begin
                        areg_ctrl = CTRL_LOAD;
                        add_sub   = 1'b1;
                    end
                    default: areg_ctrl = CTRL_HOLD;
                endcase
                state_d = StShift;
            end
            StShift: begin
                areg_ctrl = CTRL_SHR;
                busy      = 1'b1;
                q_shift   = 1'b1;
                // Saturate at zero so a corrupted count can never wrap.
                count_d   = (count_q != '0) ? count_q - CW'(1) : '0;
                state_d   = (count_q <= CW'(1)) ? StDone : StEval;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef BOOTH_SEQ_ABORT_EN
        // Abort leaves Q untouched and drops straight back to idle.
        if (abort && (state_q == StInit || state_q == StEval || state_q == StShift)) begin
            state_d = StIdle;
            q_load  = 1'b0;
            q_shift = 1'b0;
            count_d = count_q;
        end
`endif
    end

    assign q_out = q;

endmodule

// File: tb/tb_booth_seq.sv
// Self-checking bench for booth_seq: models the A register and compares products with signed arithmetic.
module tb_booth_seq;
    import booth_pkg::*;

    localparam int unsigned W = 4;

    logic           clock = 1'b0;
    logic           resetn;
    logic           start;
    logic [W-1:0]   multiplier;
    logic           a_lsb;
    logic [1:0]     areg_ctrl;
    logic           add_sub;
    logic [W-1:0]   q_out;
    logic           busy;
    logic           done;
`ifdef BOOTH_SEQ_ABORT_EN
    logic           abort;
`endif

    logic [W-1:0]   m_val;
    logic [W:0]     m_ext;
    logic [W:0]     a_reg;  // one guard bit keeps the most-negative multiplicand exact
    int             total = 0;
    int             bad   = 0;

    always #5 clock = ~clock;

    booth_seq #(
        .WIDTH(W)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
`ifdef BOOTH_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .multiplier (multiplier),
        .a_lsb      (a_lsb),
        .areg_ctrl  (areg_ctrl),
        .add_sub    (add_sub),
        .q_out      (q_out),
        .busy       (busy),
        .done       (done)
    );

    assign m_ext = {m_val[W-1], m_val};
    assign a_lsb = a_reg[0];

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_reg <= '0;
        end else begin
            case (areg_ctrl)
                CTRL_LOAD:  a_reg <= add_sub ? a_reg - m_ext : a_reg + m_ext;
                CTRL_CLEAR: a_reg <= '0;
                CTRL_SHR:   a_reg <= {a_reg[W], a_reg[W:1]};
                default:    a_reg <= a_reg;
            endcase
        end
    end

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] m, input logic [W-1:0] mq);
        int p;
        p = int'($signed(m)) * int'($signed(mq));
        return (2*W)'(p);
    endfunction

    // Runs one operation from IDLE; start is raised again in cycles p1/p2 (0 = never).
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] mq, input int p1, input int p2,
                          output logic [2*W-1:0] prod, output int done_cyc, output int n_done,
                          output bit saw_load, output bit idle_end);
        m_val = m;
        multiplier = mq;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        prod = '0;
        done_cyc = 0;
        n_done = 0;
        saw_load = 1'b0;
        for (int c = 1; c <= 2 * W + 8; c++) begin
            @(negedge clock);
            if (done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    prod = {a_reg[W-1:0], q_out};
                end
            end
            if (areg_ctrl == CTRL_LOAD) saw_load = 1'b1;
            start = (c == p1) || (c == p2);
        end
        start = 1'b0;
        idle_end = !busy && !done && (areg_ctrl == CTRL_HOLD);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (areg_ctrl !== CTRL_HOLD) begin bad++; $display("FAIL reset_ctrl got=%b want=11", areg_ctrl); end
        total++; if (add_sub !== 1'b0) begin bad++; $display("FAIL reset_addsub got=%b want=0", add_sub); end
        total++; if (q_out !== '0) begin bad++; $display("FAIL reset_q got=%h want=0", q_out); end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [W-1:0]   m_tab [4] = '{4'd3, 4'b1101, 4'b1000, 4'd5};
        logic [W-1:0]   q_tab [4] = '{4'd5, 4'd2,    4'b1000, 4'd0};
        logic [2*W-1:0] p_tab [4] = '{8'h0F, 8'hFA,  8'h40,   8'h00};
        logic [2*W-1:0] prod;
        int dc, nd;
        bit sl, ie;
        for (int i = 0; i < 4; i++) begin
            run_op(m_tab[i], q_tab[i], 0, 0, prod, dc, nd, sl, ie);
            total++; if (prod !== p_tab[i]) begin bad++; $display("FAIL dir%0d_prod got=%h want=%h", i, prod, p_tab[i]); end
            total++; if (dc != 2 * W + 2) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, dc, 2 * W + 2); end
            total++; if (nd != 1) begin bad++; $display("FAIL dir%0d_ndone got=%0d want=1", i, nd); end
            if (i == 3) begin
                total++; if (sl !== 1'b0) begin bad++; $display("FAIL zero_noload got=%b want=0", sl); end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   m, mq;
        logic [2*W-1:0] prod, exp_p;
        int dc, nd;
        bit sl, ie;
        for (int i = 0; i < 20; i++) begin
            m = W'($urandom);
            mq = W'($urandom);
            exp_p = ref_product(m, mq);
            run_op(m, mq, 0, 0, prod, dc, nd, sl, ie);
            total++; if (prod !== exp_p) begin bad++; $display("FAIL rnd_prod m=%h q=%h got=%h want=%h", m, mq, prod, exp_p); end
            total++; if (nd != 1 || dc != 2 * W + 2) begin bad++; $display("FAIL rnd_done got=%0d@%0d want=1@%0d", nd, dc, 2 * W + 2); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] prod;
        int dc, nd;
        bit sl, ie;
        run_op(4'd3, 4'd5, 3, 2 * W + 2, prod, dc, nd, sl, ie);
        total++; if (nd != 1) begin bad++; $display("FAIL b2b_ndone got=%0d want=1", nd); end
        total++; if (prod !== 8'h0F) begin bad++; $display("FAIL b2b_prod got=%h want=0f", prod); end
        total++; if (ie !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", ie); end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] prod;
        int dc, nd, seen;
        bit sl, ie;
        m_val = 4'd7;
        multiplier = 4'd6;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        total++; if (areg_ctrl !== CTRL_HOLD) begin bad++; $display("FAIL rmid_ctrl got=%b want=11", areg_ctrl); end
        total++; if (q_out !== '0) begin bad++; $display("FAIL rmid_q got=%h want=0", q_out); end
        seen = 0;
        for (int c = 0; c < 2 * W + 4; c++) begin
            @(negedge clock);
            if (c == 2) resetn = 1'b1;
            if (done) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rmid_nodone got=%0d want=0", seen); end
        run_op(4'd3, 4'd5, 0, 0, prod, dc, nd, sl, ie);
        total++; if (prod !== 8'h0F) begin bad++; $display("FAIL rmid_prod got=%h want=0f", prod); end
        total++; if (dc != 2 * W + 2 || nd != 1) begin bad++; $display("FAIL rmid_done got=%0d@%0d want=1@%0d", nd, dc, 2 * W + 2); end
    endtask

`ifdef BOOTH_SEQ_ABORT_EN
    task automatic test_abort();
        logic [W-1:0] q_hold;
        int seen;
        m_val = 4'd3;
        multiplier = 4'd5;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c < 4; c++) @(negedge clock);
        @(negedge clock);
        abort = 1'b1;
        q_hold = q_out;
        @(posedge clock);
        #1 abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (areg_ctrl !== CTRL_HOLD) begin bad++; $display("FAIL abort_ctrl got=%b want=11", areg_ctrl); end
        total++; if (q_out !== q_hold) begin bad++; $display("FAIL abort_q got=%h want=%h", q_out, q_hold); end
        seen = 0;
        for (int c = 0; c < 2 * W + 4; c++) begin
            @(negedge clock);
            if (done) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_nodone got=%0d want=0", seen); end
    endtask
`endif

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        multiplier = '0;
        m_val = '0;
`ifdef BOOTH_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef BOOTH_SEQ_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
